// File: rtl/traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : traffic_input_conditioner
// Brief    : Synchronizes and debounces the raw field inputs of the traffic
//            light controller and sequences pedestrian requests against the
//            controller's lamp feedback. Also handles preset-add pulses,
//            preemption hold and the post-service cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int PREEMPT_HOLD    = 8
) (
  input  logic       clk,
  input  logic       rst,            // asynchronous, active low
  input  logic       ped_btn_raw,
  input  logic       preempt_raw,
  input  logic       preset_sw_raw,
  input  logic       add_btn_raw,
  input  logic       pref_sw_raw,
  input  logic [0:2] leds,           // 100 green, 010 yellow, 001 red, 000 attention
  output logic       attention,
  output logic       force_red,
  output logic       preset,
  output logic       preset_add,
  output logic       preferential,
  output logic       ped_wait
);

  // Input bit positions inside the synchronizer/debouncer vectors
  localparam int c_NIN    = 5;
  localparam int c_PED    = 0;
  localparam int c_PRE    = 1;
  localparam int c_PRESET = 2;
  localparam int c_ADD    = 3;
  localparam int c_PREF   = 4;

  localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  // A zero hold still needs a one-bit register to keep the logic legal
  localparam int c_HOLD_W = (PREEMPT_HOLD > 0) ? $clog2(PREEMPT_HOLD + 1) : 1;

  localparam logic [c_DEB_W-1:0]  c_DEB_MAX   = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_COOL_W-1:0] c_COOL_INIT = c_COOL_W'(COOLDOWN_CYCLES);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(PREEMPT_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  logic [c_NIN-1:0]    w_raw;
  logic [c_NIN-1:0]    r_sync1;
  logic [c_NIN-1:0]    r_sync2;
  logic [c_NIN-1:0]    w_deb;
  logic [c_NIN-1:0]    w_deb_nxt;

  logic                r_ped_d;
  logic                r_add_d;
  logic                r_preset_add;
  logic                w_ped_rise;

  logic [c_HOLD_W-1:0] r_hold;
  logic                w_pre_fall;
  logic                w_force_red;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_COOL_W-1:0] r_cool_cnt;
  logic                r_pending;
  logic                w_cool_done;
  logic                w_attn;
  logic                w_ped_wait;

  assign w_raw = {pref_sw_raw, add_btn_raw, preset_sw_raw, preempt_raw, ped_btn_raw};

  // Two-flop synchronizer for every raw input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per input; any sample matching the current level restarts
  // the count, so only an unbroken run of DEBOUNCE_CYCLES samples flips it.
  for (genvar gi = 0; gi < c_NIN; gi++) begin : g_deb
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_deb;

    assign w_deb_nxt[gi] = ((r_sync2[gi] != r_deb) && (r_cnt == c_DEB_MAX)) ?
                           r_sync2[gi] : r_deb;
    assign w_deb[gi]     = r_deb;

    // Stability counter and accepted level
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else begin
        r_deb <= w_deb_nxt[gi];
        if ((r_sync2[gi] == r_deb) || (r_cnt == c_DEB_MAX)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_DEB_W'(1);
        end
      end
    end
  end

  assign w_ped_rise = w_deb[c_PED] & ~r_ped_d;

  // Edge-detect history and the preset-add pulse (gated by preset mode)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped_d      <= 1'b0;
      r_add_d      <= 1'b0;
      r_preset_add <= 1'b0;
    end else begin
      r_ped_d      <= w_deb[c_PED];
      r_add_d      <= w_deb[c_ADD];
      r_preset_add <= w_deb[c_ADD] & ~r_add_d & w_deb[c_PRESET];
    end
  end

  // The fall is detected on the edge the debounced level drops, so the hold
  // count is loaded in the same edge and force_red has no one-cycle gap.
  assign w_pre_fall  = w_deb[c_PRE] & ~w_deb_nxt[c_PRE];
  assign w_force_red = w_deb[c_PRE] | (r_hold != '0);

  // Preemption hold countdown; a re-rise cancels any remaining hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_pre_fall) begin
      r_hold <= c_HOLD_INIT;
    end else if (w_deb[c_PRE]) begin
      r_hold <= '0;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - c_HOLD_W'(1);
    end
  end

  // Pedestrian FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_cool_done = (r_cool_cnt <= c_COOL_W'(1));

  // Pedestrian FSM next state and outputs; preemption overrides an issue
  always_comb begin
    w_state_nxt = r_state;
    w_attn      = 1'b0;
    w_ped_wait  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ped_rise) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_ped_wait = 1'b1;
        if ((leds == 3'b100) && !w_force_red) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_ped_wait = 1'b1;
        w_attn     = ~w_force_red;
        if (w_force_red) begin
          w_state_nxt = ST_WAIT;
        end else if (leds == 3'b000) begin
          w_state_nxt = ST_COOL;
        end
      end
      ST_COOL: begin
        if (w_cool_done) begin
          w_state_nxt = (r_pending || w_ped_rise) ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Cooldown counter and the press-during-cooldown pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cool_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      if ((r_state != ST_COOL) && (w_state_nxt == ST_COOL)) begin
        r_cool_cnt <= c_COOL_INIT;
      end else if ((r_state == ST_COOL) && (r_cool_cnt != '0)) begin
        r_cool_cnt <= r_cool_cnt - c_COOL_W'(1);
      end

      if (r_state != ST_COOL) begin
        r_pending <= 1'b0;
      end else if (w_cool_done) begin
        r_pending <= 1'b0;
      end else if (w_ped_rise) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign attention    = w_attn;
  assign ped_wait     = w_ped_wait;
  assign force_red    = w_force_red;
  assign preset       = w_deb[c_PRESET];
  assign preferential = w_deb[c_PREF];
  assign preset_add   = r_preset_add;

endmodule
`default_nettype wire

// File: tb/tb_traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_input_conditioner
// Brief    : Directed, table-driven bench for traffic_input_conditioner with
//            hand-written sequences for the multi-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_input_conditioner;

  logic       clk;
  logic       rst;
  logic       ped_btn_raw;
  logic       preempt_raw;
  logic       preset_sw_raw;
  logic       add_btn_raw;
  logic       pref_sw_raw;
  logic [0:2] leds;
  logic       attention;
  logic       force_red;
  logic       preset;
  logic       preset_add;
  logic       preferential;
  logic       ped_wait;
  logic [5:0] w_out;

  int n_checks = 0;
  int n_errors = 0;

  traffic_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(16),
    .PREEMPT_HOLD   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ped_btn_raw  (ped_btn_raw),
    .preempt_raw  (preempt_raw),
    .preset_sw_raw(preset_sw_raw),
    .add_btn_raw  (add_btn_raw),
    .pref_sw_raw  (pref_sw_raw),
    .leds         (leds),
    .attention    (attention),
    .force_red    (force_red),
    .preset       (preset),
    .preset_add   (preset_add),
    .preferential (preferential),
    .ped_wait     (ped_wait)
  );

  // Output bundle: {attention, force_red, preset, preset_add, preferential, ped_wait}
  assign w_out = {attention, force_red, preset, preset_add, preferential, ped_wait};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ped;
    logic       pre;
    logic       psw;
    logic       add;
    logic       pref;
    logic [2:0] leds;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    int idx;
    logic seen;

    // A raw change driven just after an edge is captured on the next edge,
    // debounced 5 edges later, so levels move on the 6th tick and FSM/pulse
    // effects on the 7th.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001,  3, 6'b000000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001,  8, 6'b001010};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001,  8, 6'b001000};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001,  8, 6'b001001};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100,  1, 6'b101001};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000,  1, 6'b001000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 20, 6'b001000};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001,  8, 6'b011000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 20, 6'b001000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001,  8, 6'b000000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001,  7, 6'b001100};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001,  1, 6'b001000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001,  8, 6'b000000};

    rst = 1'b0;
    ped_btn_raw = 1'b0; preempt_raw = 1'b0; preset_sw_raw = 1'b0;
    add_btn_raw = 1'b0; pref_sw_raw = 1'b0; leds = 3'b001;
    repeat (3) tick();
    chk("reset_outputs", w_out, 6'b000000);
    rst = 1'b1;

    // Table-driven vectors
    for (int r = 0; r < 13; r++) begin
      ped_btn_raw   = tbl[r].ped;
      preempt_raw   = tbl[r].pre;
      preset_sw_raw = tbl[r].psw;
      add_btn_raw   = tbl[r].add;
      pref_sw_raw   = tbl[r].pref;
      leds          = tbl[r].leds;
      repeat (tbl[r].n) tick();
      chk($sformatf("vec%0d", r), w_out, tbl[r].exp);
    end

    // Short 3-cycle glitch must not register a request
    ped_btn_raw = 1'b1;
    repeat (3) tick();
    ped_btn_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ped_wait) seen = 1'b1;
    end
    chk("glitch_no_wait", seen, 1'b0);

    // Held press: ped_wait rises on the 7th edge after the raw change
    ped_btn_raw = 1'b1;
    idx = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ped_wait && idx == 0) idx = i;
    end
    chk("ped_wait_latency", idx, 7);
    chk("red_no_attention", attention, 1'b0);
    ped_btn_raw = 1'b0;

    leds = 3'b100;
    tick();
    chk("green_attention", attention, 1'b1);

    // Preemption during ISSUE drops attention as force_red rises
    preempt_raw = 1'b1;
    repeat (5) tick();
    chk("issue_before_preempt", {attention, force_red}, 2'b10);
    tick();
    chk("preempt_in_issue", {attention, force_red, ped_wait}, 3'b011);
    tick();
    chk("back_to_wait", {attention, ped_wait}, 2'b01);

    // Release: 6 ticks of debounce plus 8 cycles of hold
    preempt_raw = 1'b0;
    idx = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (!force_red && idx == 0) idx = i;
    end
    chk("preempt_hold_len", idx, 14);
    // leds still green, FSM already re-issued after the hold expired
    chk("reissue_after_hold", attention, 1'b1);

    // Serve, then cooldown with a press at cooldown cycle 5
    leds = 3'b000;
    tick();
    chk("served", {attention, ped_wait}, 2'b00);
    leds = 3'b100;
    seen = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (attention) seen = 1'b1;
      if (i == 5) ped_btn_raw = 1'b1;
      if (i == 15) chk("cool_still_idle", ped_wait, 1'b0);
    end
    chk("cool_no_attention", seen, 1'b0);
    chk("cool_expiry_wait", {attention, ped_wait}, 2'b01);
    tick();
    chk("cool_pending_issue", attention, 1'b1);
    leds = 3'b000;
    tick();
    ped_btn_raw = 1'b0;
    leds = 3'b001;
    repeat (20) tick();
    chk("idle_after_cool", {attention, ped_wait}, 2'b00);

    // Preset add: one pulse for a long hold, timed on the 7th tick
    preset_sw_raw = 1'b1;
    repeat (8) tick();
    add_btn_raw = 1'b1;
    cnt = 0; idx = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (preset_add) begin
        cnt++;
        if (idx == 0) idx = i;
      end
    end
    chk("add_pulse_count", cnt, 1);
    chk("add_pulse_time", idx, 7);
    add_btn_raw = 1'b0;
    repeat (10) tick();
    preset_sw_raw = 1'b0;
    repeat (8) tick();
    add_btn_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (preset_add) cnt++;
    end
    chk("add_no_preset", cnt, 0);
    add_btn_raw = 1'b0;
    repeat (8) tick();

    // Async reset in the middle of ISSUE
    ped_btn_raw = 1'b1;
    repeat (8) tick();
    ped_btn_raw = 1'b0;
    leds = 3'b100;
    tick();
    chk("pre_reset_issue", attention, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_issue", w_out, 6'b000000);
    #2;
    rst = 1'b1;
    leds = 3'b001;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (w_out != 6'b000000) seen = 1'b1;
    end
    chk("no_stale_after_reset1", seen, 1'b0);

    // Async reset in the middle of the preemption hold
    preset_sw_raw = 1'b1;
    preempt_raw = 1'b1;
    repeat (8) tick();
    preempt_raw = 1'b0;
    repeat (9) tick();
    chk("hold_active", {force_red, preset}, 2'b11);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_hold", w_out, 6'b000000);
    preset_sw_raw = 1'b0;
    #2;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (w_out != 6'b000000) seen = 1'b1;
    end
    chk("no_stale_after_reset2", seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
